// File: rtl/pipe_pkg.sv
// Shared types and width constants for the pipeline hazard controller.
package pipe_pkg;

  localparam int REG_W  = 6;   // register-specifier width
  localparam int CNT_W  = 8;   // MDU stall counter width
  localparam int WDOG_W = 16;  // memory-wait watchdog width

  typedef enum logic {
    RUN = 1'b0,
    MDU = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination of
// a load currently in EX. Register 0 is hardwired and never creates a hazard.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_mem_to_reg,
  input  logic             ex_reg_write,
  output logic             ldu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs & (id_rs == ex_write_reg);
  assign rt_hit = id_use_rt & (id_rt == ex_write_reg);
  assign ldu    = ex_mem_to_reg & ex_reg_write & (ex_write_reg != '0) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Resolves memory
// wait, multi-cycle MDU, taken branch and load-use hazards in that priority
// order, and keeps a sticky watchdog flag for over-long memory waits.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MDU_LAT     = 8,   // 2..255, stall cycles incl. issue cycle
  parameter int MEM_TIMEOUT = 64   // 1..65535, wait cycles before mem_err
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_useRs,
  input  logic             id_useRt,
  input  logic [REG_W-1:0] ex_writeReg,
  input  logic             ex_MemToReg,
  input  logic             ex_RegWrite,
  input  logic             ex_mdu,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             mdu_busy,
  output logic             mem_err
);

  localparam logic [CNT_W-1:0]  MDU_LOAD  = CNT_W'(MDU_LAT - 1);
  localparam logic [WDOG_W-1:0] WAIT_LAST = WDOG_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  mdu_cnt, mdu_cnt_nxt;
  logic              mdu_done, mdu_done_nxt;
  logic [WDOG_W-1:0] wait_cnt;
  logic              memw;
  logic              mdus;
  logic              ldu;

  hazard_detect u_hazard_detect (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_use_rs     (id_useRs),
    .id_use_rt     (id_useRt),
    .ex_write_reg  (ex_writeReg),
    .ex_mem_to_reg (ex_MemToReg),
    .ex_reg_write  (ex_RegWrite),
    .ldu           (ldu)
  );

  assign memw = mem_req & ~dm_ready;
  assign mdus = ((state == RUN) & ex_mdu & ~mdu_done) | (state == MDU);

  // Output priority and FSM next-state; the MDU counter freezes under memw.
  always_comb begin
    // NOTE: every output and next-state signal gets a default first, so no
    // path through the if/case chain can leave one unassigned (no latches).
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_flush  = 1'b0;
    memwb_flush  = 1'b0;
    mdu_busy     = (state == MDU);
    state_nxt    = state;
    mdu_cnt_nxt  = mdu_cnt;
    mdu_done_nxt = mdu_done;

    if (!clr) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
      mdu_busy    = 1'b0;
    end else if (memw) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (mdus) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // The load-use consumer sits in ID and is squashed, so no stall.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (ldu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end

    // The finished MDU instruction leaving EX re-arms issue for the next one.
    if ((state == RUN) && exmem_en && !exmem_flush) mdu_done_nxt = 1'b0;

    case (state)
      RUN: begin
        if (ex_mdu && !mdu_done && !memw) begin
          state_nxt   = MDU;
          mdu_cnt_nxt = MDU_LOAD;
        end
      end
      MDU: begin
        if (!memw) begin
          if (mdu_cnt == CNT_W'(1)) begin
            state_nxt    = RUN;
            mdu_done_nxt = 1'b1;
          end else begin
            mdu_cnt_nxt = mdu_cnt - CNT_W'(1);
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // FSM and MDU counter registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!clr) begin
      state    <= RUN;
      mdu_cnt  <= '0;
      mdu_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      mdu_cnt  <= mdu_cnt_nxt;
      mdu_done <= mdu_done_nxt;
    end
  end

  // Memory watchdog: counts consecutive wait cycles, sets a sticky error.
  always_ff @(posedge clk) begin
    if (!clr) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (memw) begin
      if (wait_cnt != '1) wait_cnt <= wait_cnt + WDOG_W'(1);
      if (wait_cnt == WAIT_LAST) mem_err <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT     = 8;
  localparam int MEM_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [5:0] id_rs, id_rt, ex_writeReg;
  logic       id_useRs, id_useRt, ex_MemToReg, ex_RegWrite;
  logic       ex_mdu, ex_branch_taken, mem_req, dm_ready;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic       mdu_busy, mem_err;
  logic [10:0] outs;

  int errors = 0;
  int checks = 0;

  // Reference model state: progress of the MDU op in served stall cycles.
  int m_served = 0;
  bit m_active = 0;
  bit m_done   = 0;
  bit m_err    = 0;
  int m_wait   = 0;

  localparam logic [10:0] ALL_RUN = {5'b11111, 4'b0000, 2'b00};
  localparam logic [10:0] IN_RST  = {5'b00000, 4'b1111, 2'b00};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk             (clk),
    .clr             (clr),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_useRs        (id_useRs),
    .id_useRt        (id_useRt),
    .ex_writeReg     (ex_writeReg),
    .ex_MemToReg     (ex_MemToReg),
    .ex_RegWrite     (ex_RegWrite),
    .ex_mdu          (ex_mdu),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dm_ready        (dm_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_flush     (exmem_flush),
    .memwb_flush     (memwb_flush),
    .mdu_busy        (mdu_busy),
    .mem_err         (mem_err)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush,
                 mdu_busy, mem_err};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ldu();
    bit rs_hit = id_useRs && (id_rs == ex_writeReg);
    bit rt_hit = id_useRt && (id_rt == ex_writeReg);
    return ex_MemToReg && ex_RegWrite && (ex_writeReg != 0) && (rs_hit || rt_hit);
  endfunction

  function automatic bit model_mdus();
    return m_active || (ex_mdu && !m_done);
  endfunction

  // Expected outputs from the priority rules and the model's state.
  function automatic logic [10:0] model_out();
    bit memw = mem_req && !dm_ready;
    logic [4:0] en = 5'b11111;   // pc, ifid, idex, exmem, memwb
    logic [3:0] fl = 4'b0000;    // ifid, idex, exmem, memwb
    if (!clr) return {5'b00000, 4'b1111, 1'b0, m_err};
    if (memw) begin
      en = 5'b00001; fl = 4'b0001;
    end else if (model_mdus()) begin
      en = 5'b00011; fl = 4'b0010;
    end else if (ex_branch_taken) begin
      fl = 4'b1100;
    end else if (model_ldu()) begin
      en = 5'b00111; fl = 4'b0100;
    end
    return {en, fl, m_active, m_err};
  endfunction

  // Advance the model across one clock edge using the held inputs.
  task automatic model_step();
    bit memw = mem_req && !dm_ready;
    bit mdus = model_mdus();
    if (!clr) begin
      m_served = 0; m_active = 0; m_done = 0; m_err = 0; m_wait = 0;
    end else begin
      if (memw) begin
        m_wait++;
        if (m_wait == MEM_TIMEOUT) m_err = 1;
      end else begin
        m_wait = 0;
        if (mdus) begin
          m_served++;
          if (m_served == MDU_LAT) begin
            m_served = 0; m_active = 0; m_done = 1;
          end else begin
            m_active = 1;
          end
        end else begin
          m_done = 0;
        end
      end
    end
  endtask

  // Compare against the model, then clock once with the current inputs.
  task automatic cycle(input string tag);
    #1;
    check(tag, outs, model_out());
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_useRs = 0; id_useRt = 0;
    ex_writeReg = 0; ex_MemToReg = 0; ex_RegWrite = 0;
    ex_mdu = 0; ex_branch_taken = 0; mem_req = 0; dm_ready = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls;
    bit fin;

    clr = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    #1; check("rst_vec", outs, IN_RST);
    cycle("rst");
    clr = 1'b1;
    #1; check("run_vec", outs, ALL_RUN);
    cycle("run");

    // Load-use on rs, then bubble in EX
    ex_MemToReg = 1; ex_RegWrite = 1; ex_writeReg = 5; id_rs = 5; id_useRs = 1;
    #1; check("ldu_vec", outs, {5'b00111, 4'b0100, 2'b00});
    cycle("ldu");
    ex_MemToReg = 0; ex_RegWrite = 0; ex_writeReg = 0;
    #1; check("ldu_after", outs, ALL_RUN);
    cycle("ldu_after");

    // Destination register 0 never stalls
    ex_MemToReg = 1; ex_RegWrite = 1; ex_writeReg = 0; id_rs = 0; id_useRs = 1;
    #1; check("ldu_r0", outs, ALL_RUN);
    cycle("ldu_r0");
    // Load-use on rt only
    ex_writeReg = 9; id_rt = 9; id_useRt = 1; id_useRs = 0;
    #1; check("ldu_rt_idex_flush", idex_flush, 1);
    cycle("ldu_rt");
    idle_inputs();

    // MDU held high: MDU_LAT stall cycles, then EX advances without re-stall
    for (int i = 0; i <= MDU_LAT; i++) begin
      ex_mdu = 1;
      #1;
      if (i < MDU_LAT) begin
        check("mdu_pc_en", pc_en, 0);
        check("mdu_exmem_flush", exmem_flush, 1);
        check("mdu_busy", mdu_busy, (i >= 1) ? 1 : 0);
      end else begin
        check("mdu_release", outs, ALL_RUN);
      end
      cycle("mdu");
    end
    ex_mdu = 0;
    cycle("mdu_idle");

    // Memory wait for three cycles, then ready
    for (int i = 0; i < 4; i++) begin
      mem_req = 1; dm_ready = (i == 3);
      #1;
      check("memw_vec", outs, (i < 3) ? {5'b00001, 4'b0001, 2'b00} : ALL_RUN);
      cycle("memw");
    end
    idle_inputs();

    // MDU with two memw cycles in the middle: ten stall cycles in total
    stalls = 0; fin = 0;
    ex_mdu = 1;
    for (int i = 0; i < 20 && !fin; i++) begin
      mem_req = (i == 3 || i == 4); dm_ready = 0;
      #1;
      if (i == 3) check("ovl_busy", mdu_busy, 1);
      if (pc_en) fin = 1; else stalls++;
      cycle("ovl");
    end
    idle_inputs();
    check("ovl_stalls", stalls, MDU_LAT + 2);
    cycle("ovl_idle");

    // Taken branch with a load-use match: front-end flush only
    ex_MemToReg = 1; ex_RegWrite = 1; ex_writeReg = 7; id_rt = 7; id_useRt = 1;
    ex_branch_taken = 1;
    #1; check("br_ldu_vec", outs, {5'b11111, 4'b1100, 2'b00});
    cycle("br_ldu");
    idle_inputs();

    // Reset in the middle of an MDU operation aborts it
    ex_mdu = 1;
    repeat (3) cycle("mdu_abort_run");
    clr = 0;
    cycle("mdu_abort_rst");
    clr = 1; ex_mdu = 0;
    #1; check("mdu_abort_vec", outs, ALL_RUN);
    cycle("mdu_abort_after");

    // Watchdog: five wait cycles, sticky error, cleared only by reset
    for (int i = 0; i < 5; i++) begin
      mem_req = 1; dm_ready = 0;
      #1; check("wd_err", mem_err, (i >= MEM_TIMEOUT) ? 1 : 0);
      cycle("wd");
    end
    idle_inputs();
    #1; check("wd_sticky", outs, {5'b11111, 4'b0000, 2'b01});
    cycle("wd_sticky");
    clr = 0;
    #1; check("wd_rst_pre", outs, {5'b00000, 4'b1111, 2'b01});
    cycle("wd_rst");
    #1; check("wd_rst_post", outs, IN_RST);
    clr = 1;
    cycle("wd_clear");

    // Randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      clr             = ($urandom_range(0, 39) != 0);
      id_rs           = 6'($urandom_range(0, 3));
      id_rt           = 6'($urandom_range(0, 3));
      id_useRs        = 1'($urandom_range(0, 1));
      id_useRt        = 1'($urandom_range(0, 1));
      ex_writeReg     = 6'($urandom_range(0, 3));
      ex_MemToReg     = 1'($urandom_range(0, 1));
      ex_RegWrite     = 1'($urandom_range(0, 1));
      ex_mdu          = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      dm_ready        = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. Drives hold-enable and bubble-flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves four hazard sources:
  - load-use (1-cycle stall);
  - multi-cycle MDU operation in EX (counted stall);
  - data-memory wait in MEM (ready handshake, with watchdog);
  - taken branch in EX (front-end flush).

Parameters:
- MDU_LAT, 8, total EX-stall cycles for a mult/div, including the issue cycle; legal range 2..255.
- MEM_TIMEOUT, 64, consecutive dm-wait cycles before mem_err sets; legal range 1..65535.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- clr  in  1  synchronous active-low reset.
- id_rs  in  6  ID-stage source register A.
- id_rt  in  6  ID-stage source register B.
- id_useRs  in  1  ID instruction reads rs.
- id_useRt  in  1  ID instruction reads rt.
- ex_writeReg  in  6  EX-stage destination register.
- ex_MemToReg  in  1  EX instruction is a load.
- ex_RegWrite  in  1  EX instruction writes the register file.
- ex_mdu  in  1  EX instruction is a multi-cycle mult/div.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MEM instruction accesses data memory.
- dm_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID load enable.
- idex_en  out  1  ID/EX load enable.
- exmem_en  out  1  EX/MEM load enable.
- memwb_en  out  1  MEM/WB load enable.
- ifid_flush  out  1  IF/ID loads zero.
- idex_flush  out  1  ID/EX loads zero.
- exmem_flush  out  1  EX/MEM loads zero.
- memwb_flush  out  1  MEM/WB loads zero.
- mdu_busy  out  1  FSM in MDU state.
- mem_err  out  1  sticky memory-timeout flag.

Behaviour:
- Convention:
  - en=0 holds the register.
  - flush=1 loads all-zero (bubble, RegWrite=0) and overrides en.
  - All outputs are combinational from state plus inputs.
- Reset (clr=0 at posedge):
  - state=RUN, mdu_cnt=0, mdu_done=0, wait_cnt=0, mem_err=0.
  - While clr=0: all *_en=0, all *_flush=1, mdu_busy=0.
- Conditions:
  - memw = mem_req & ~dm_ready.
  - ldu = ex_MemToReg & ex_RegWrite & ex_writeReg!=0 & ((id_useRs & id_rs==ex_writeReg) | (id_useRt & id_rt==ex_writeReg)).
  - mdus = (state==RUN & ex_mdu & ~mdu_done) | state==MDU.
- Priority, highest first:
  1. memw: pc/ifid/idex/exmem en=0; memwb_flush=1.
  2. mdus: pc/ifid/idex en=0; exmem_flush=1; memwb_en=1.
  3. branch (ex_branch_taken): ifid_flush=1, idex_flush=1, others en=1. Load-use is suppressed this cycle because the consumer is squashed.
  4. ldu: pc/ifid en=0; idex_flush=1; exmem/memwb en=1.
  5. Otherwise: all en=1, no flush.
- FSM states: RUN, MDU.
  - RUN → MDU when ex_mdu & ~mdu_done & ~memw; mdu_cnt loads MDU_LAT-1.
  - In MDU, mdu_cnt decrements each cycle that ~memw (frozen while memw).
  - MDU → RUN when mdu_cnt==1 and ~memw; mdu_done is set at the same time.
  - Result: exactly MDU_LAT stall cycles with no memw overlap. EX advances on the cycle after mdu_done is set.
- mdu_done:
  - Cleared on any edge where exmem_en=1 & ~exmem_flush & state==RUN, i.e. the MDU instruction leaves EX.
  - Prevents re-issue of the same instruction.
- Memory watchdog:
  - wait_cnt increments while memw; cleared when ~memw.
  - mem_err sets on the edge where wait_cnt reaches MEM_TIMEOUT; cleared only by reset.
  - mem_err does not alter the stall outputs.
- Boundary cases:
  - Reset mid-MDU aborts the operation immediately.
  - memw with ex_mdu rising holds the FSM in RUN until memw drops.
  - ex_writeReg==0 never triggers ldu.
  - Back-to-back MDU instructions each get a full MDU_LAT stall.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (RUN=1'b0, MDU=1'b1);
  - width constants: REG_W=6, CNT_W=8, WDOG_W=16.
- One natural sub-module: hazard_detect, the combinational ldu comparator, which is reusable by the forwarding unit.
- FSM, counters and output priority stay in the top module.

Test Plan:
- Load-use: ex_MemToReg=1, ex_RegWrite=1, ex_writeReg=5, id_rs=5, id_useRs=1 → one cycle with pc_en=0, ifid_en=0, idex_flush=1; the next cycle, with bubble in EX, all en=1.
- MDU, MDU_LAT=8: ex_mdu held high from cycle T → pc_en=0 and exmem_flush=1 for cycles T..T+7; mdu_busy=1 for T+1..T+7; all en=1 at T+8; no re-stall.
- Memory wait: mem_req=1, dm_ready=0 for 3 cycles, then 1 → pc/ifid/idex/exmem en=0 and memwb_flush=1 for 3 cycles; normal operation on the 4th.
- Overlap: MDU starts, memw asserted 2 cycles mid-operation → total MDU stall is 10 cycles; counter frozen during memw.
- Branch: ex_branch_taken=1 together with an ldu match → ifid_flush=1, idex_flush=1, pc_en=1.
- Watchdog and reset: MEM_TIMEOUT=4, dm_ready low for 5 cycles → mem_err=1 and stays set; clr=0 for one edge → mem_err=0 and all flushes=1 while clr is low.
